pl_stage_multi_ctrl: RTL

- Parametrised N-channel controller for one pipeline stage of the NewHope datapath.
- Takes a stage start, launches up to NUM_CH compute units (NTT/INTT/pointwise) with a per-run channel mask, and collects their done pulses as sticky flags.
- Raises done_stage only when all enabled channels finish, or when a watchdog expires.
- Toggles a ping-pong bank select on each good completion so that ownership of the output buffers passes to the next stage.

---
 rtl/pl_stage_multi_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/pl_stage_multi_ctrl.sv
// pl_stage_multi_ctrl: launches masked compute channels, gathers their done pulses, flips the ping-pong bank on good completion
module pl_stage_multi_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start_stage,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic [NUM_CH-1:0]    start_ch,
  input  logic [NUM_CH-1:0]    done_ch,
  output logic                 busy,
  output logic                 done_stage,
  output logic [NUM_CH-1:0]    done_flags,
  output logic                 timeout_err,
  output logic                 overrun_err,
  output logic                 bank_sel,
  output logic [TIMEOUT_W-1:0] last_latency
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;
  state_t               state;
  logic [NUM_CH-1:0]    mask_q, flags_nx;
  logic [TIMEOUT_W-1:0] to_q, cnt, cnt_nx;
  logic                 complete, expire;
  // cnt_nx is the cycle count including the current cycle; completion and watchdog judge against it
  always_comb begin
    flags_nx = done_flags | (done_ch & mask_q);
    cnt_nx   = &cnt ? cnt : cnt + 1'b1;
    complete = flags_nx == mask_q;
    expire   = to_q != '0 && cnt_nx == to_q;
  end
  // stage FSM; start_ch is held with the FSM while en is low so units sharing en see one enabled start
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mask_q       <= '0;
      to_q         <= '0;
      cnt          <= '0;
      start_ch     <= '0;
      busy         <= 1'b0;
      done_stage   <= 1'b0;
      done_flags   <= '0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      bank_sel     <= 1'b0;
      last_latency <= '0;
    end else begin
      done_stage <= 1'b0;
      if (state inside {LAUNCH, WAIT}) done_flags <= flags_nx;
      if (en) begin
        if (start_stage && state inside {LAUNCH, WAIT}) overrun_err <= 1'b1;
        case (state)
          IDLE, FINISH: begin
            if (state == FINISH) begin
              done_stage <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
            if (start_stage) begin
              mask_q      <= ch_mask;
              to_q        <= timeout_cycles;
              done_flags  <= '0;
              timeout_err <= 1'b0;
              overrun_err <= 1'b0;
              cnt         <= '0;
              start_ch    <= ch_mask;
              busy        <= 1'b1;
              state       <= LAUNCH;
            end
          end
          LAUNCH: begin
            start_ch <= '0;
            cnt      <= cnt_nx;
            state    <= WAIT;
          end
          WAIT: begin
            cnt <= cnt_nx;
            if (complete || expire) begin
              state        <= FINISH;
              last_latency <= cnt_nx;
              bank_sel     <= bank_sel ^ complete;
              timeout_err  <= !complete;
            end
          end
        endcase
      end
    end
  end
endmodule
